// File: rtl/spi_master_shifter_if.sv
// FIFO-side and SPI-pin signal bundle for spi_master_shifter.
// With SPI_MODE_SEL_EN defined, cpol_i/cpha_i are added to the bundle.
interface spi_master_shifter_if #(
  parameter int unsigned g_width = 32
);
  logic               en_i;
  logic [g_width-1:0] tx_data_i;
  logic               tx_empty_i;
  logic               tx_pull_o;
  logic [g_width-1:0] rx_data_o;
  logic               rx_full_i;
  logic               rx_push_o;
  logic               sclk_o;
  logic               cs_n_o;
  logic               mosi_o;
  logic               miso_i;
  logic               busy_o;
  logic               rx_ovf_o;
`ifdef SPI_MODE_SEL_EN
  logic               cpol_i;
  logic               cpha_i;
`endif

  modport master (
    input  en_i, tx_data_i, tx_empty_i, rx_full_i, miso_i,
`ifdef SPI_MODE_SEL_EN
    input  cpol_i, cpha_i,
`endif
    output tx_pull_o, rx_data_o, rx_push_o, sclk_o, cs_n_o, mosi_o, busy_o, rx_ovf_o
  );

  modport slave (
    output en_i, tx_data_i, tx_empty_i, rx_full_i, miso_i,
`ifdef SPI_MODE_SEL_EN
    output cpol_i, cpha_i,
`endif
    input  tx_pull_o, rx_data_o, rx_push_o, sclk_o, cs_n_o, mosi_o, busy_o, rx_ovf_o
  );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI master serialiser between show-ahead TX/RX word FIFOs: MSB-first, burst-capable.
// Optional macro SPI_MODE_SEL_EN enables run-time CPOL/CPHA selection (default: mode 0).
module spi_master_shifter #(
  parameter int unsigned g_width   = 32,
  parameter int unsigned g_clk_div = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  spi_master_shifter_if.master bus
);
  localparam int unsigned CNT_W = (g_clk_div > 1) ? $clog2(g_clk_div) : 1;
  localparam int unsigned BIT_W = $clog2(g_width) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_DONE, S_TRAIL} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [g_width-1:0] tx_sr_q, tx_sr_d;
  logic [g_width-1:0] rx_sr_q, rx_sr_d;
  logic [g_width-1:0] rx_data_q, rx_data_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               push_q, push_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;

  logic cpol_in, cpha_in;
  logic start_ok, load, tick, lead_edge;

`ifdef SPI_MODE_SEL_EN
  assign cpol_in = bus.cpol_i;
  assign cpha_in = bus.cpha_i;
`else
  assign cpol_in = 1'b0;
  assign cpha_in = 1'b0;
`endif

  // The pull must coincide with the cycle that captures the FIFO head, so it is decoded, not registered.
  assign start_ok  = bus.en_i & ~bus.tx_empty_i & ~bus.rx_full_i & ~rst_i;
  assign load      = start_ok & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign tick      = (cnt_q == CNT_W'(g_clk_div - 1));
  assign lead_edge = (sclk_q == cpol_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    push_d    = 1'b0;
    ovf_d     = ovf_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;

    unique case (state_q)
      S_IDLE: begin
        sclk_d = cpol_in;
        cs_n_d = 1'b1;
        if (load) begin
          cpol_d    = cpol_in;
          cpha_d    = cpha_in;
          tx_sr_d   = bus.tx_data_i;
          rx_sr_d   = '0;
          if (!cpha_in) mosi_d = bus.tx_data_i[g_width-1];
          cnt_d     = '0;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          state_d   = S_LEAD;
        end
      end
      S_LEAD: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          sclk_d = ~sclk_q;
          if (lead_edge) begin
            if (cpha_q) begin
              mosi_d  = tx_sr_q[g_width-1];
              tx_sr_d = tx_sr_q << 1;
            end else begin
              rx_sr_d = {rx_sr_q[g_width-2:0], bus.miso_i};
            end
          end else begin
            if (cpha_q) begin
              rx_sr_d = {rx_sr_q[g_width-2:0], bus.miso_i};
            end else begin
              mosi_d  = tx_sr_q[g_width-2];
              tx_sr_d = tx_sr_q << 1;
            end
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            // Last trailing edge returns sclk to idle; no further edges for this word.
            if (bit_cnt_q == BIT_W'(g_width - 1)) begin
              rx_data_d = rx_sr_d;
              push_d    = 1'b1;
              state_d   = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        cnt_d = '0;
        if (bus.rx_full_i) ovf_d = 1'b1;
        if (load) begin
          tx_sr_d   = bus.tx_data_i;
          rx_sr_d   = '0;
          if (!cpha_q) mosi_d = bus.tx_data_i[g_width-1];
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end else begin
          state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          cs_n_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      push_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      push_q    <= push_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end

  assign bus.tx_pull_o = load;
  assign bus.rx_data_o = rx_data_q;
  assign bus.rx_push_o = push_q;
  assign bus.sclk_o    = sclk_q;
  assign bus.cs_n_o    = cs_n_q;
  assign bus.mosi_o    = mosi_q;
  assign bus.busy_o    = busy_q;
  assign bus.rx_ovf_o  = ovf_q;
endmodule

// File: tb/tb_spi_master_shifter.sv
// Scoreboard bench for spi_master_shifter (g_width=8, g_clk_div=2): TX FIFO model,
// expected RX words queued at stimulus time and checked by an independent push monitor.
module tb_spi_master_shifter;
  localparam int unsigned W = 8;
  localparam int unsigned D = 2;

  logic clk;
  logic rst;
  logic loop;
  logic miso_val;
  logic pend = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  logic [W-1:0] tx_mem [0:63];
  logic [W-1:0] exp_mem[0:63];
  int tx_wr = 0;
  int tx_rd = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  int pull_cnt = 0;
  int both_cnt = 0;
  int push_cnt = 0;
  int rise_cnt = 0;
  int cs_len   = 0;
  int cs_last  = 0;
  int cs_low   = 0;
  int bad_mosi = 0;
  logic [31:0] mosi_bits = '0;
  logic prev_sclk = 1'b0;
  logic prev_mosi = 1'b0;
  logic [W-1:0] exp_w;

  int b_pull, b_both, b_push, b_rise, b_cslow, b_bad;

  spi_master_shifter_if #(.g_width(W)) bus ();

  spi_master_shifter #(.g_width(W), .g_clk_div(D)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  assign bus.miso_i = loop ? bus.mosi_o : miso_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Show-ahead TX FIFO: a pull seen in one cycle advances the head at the next falling edge.
  always @(negedge clk) begin
    if (pend && tx_rd < tx_wr) tx_rd++;
    bus.tx_empty_i = (tx_rd >= tx_wr);
    bus.tx_data_i  = (tx_rd < tx_wr) ? tx_mem[tx_rd] : '0;
    #1;
    pend = bus.tx_pull_o;
    if (bus.tx_pull_o) begin
      pull_cnt++;
      if (bus.rx_push_o) both_cnt++;
    end
  end

  // Push monitor and SPI pin observers.
  always @(negedge clk) begin
    if (bus.rx_push_o === 1'b1) begin
      push_cnt++;
      if (exp_rd >= exp_wr) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_push: got %0h, required no push", bus.rx_data_o);
      end else begin
        exp_w = exp_mem[exp_rd];
        exp_rd++;
        check("rx_word", 32'(bus.rx_data_o), 32'(exp_w));
      end
    end
    if (bus.sclk_o === 1'b1 && prev_sclk === 1'b0) begin
      rise_cnt++;
      mosi_bits = {mosi_bits[30:0], bus.mosi_o};
    end
    if (bus.mosi_o !== prev_mosi && bus.cs_n_o === 1'b0 && !(prev_sclk === 1'b1 && bus.sclk_o === 1'b0))
      bad_mosi++;
    if (bus.cs_n_o === 1'b0) begin
      cs_len++;
      cs_low++;
    end else if (cs_len != 0) begin
      cs_last = cs_len;
      cs_len  = 0;
    end
    prev_sclk = bus.sclk_o;
    prev_mosi = bus.mosi_o;
  end

  task automatic push_tx(input logic [W-1:0] w);
    tx_mem[tx_wr] = w;
    tx_wr++;
  endtask

  task automatic push_exp(input logic [W-1:0] w);
    exp_mem[exp_wr] = w;
    exp_wr++;
  endtask

  task automatic snap();
    b_pull  = pull_cnt;
    b_both  = both_cnt;
    b_push  = push_cnt;
    b_rise  = rise_cnt;
    b_cslow = cs_low;
    b_bad   = bad_mosi;
  endtask

  task automatic wait_busy(input logic lvl, input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.busy_o === lvl) return;
    end
    n_vec++;
    n_fail++;
    $display("FAIL %s: got timeout after %0d cycles, required busy_o=%0b", name, budget, lvl);
  endtask

  task automatic wait_rise(input int target, input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rise_cnt >= target) return;
    end
    n_vec++;
    n_fail++;
    $display("FAIL %s: got %0d sclk rises, required %0d", name, rise_cnt, target);
  endtask

  task automatic run_word(input string name);
    wait_busy(1'b1, {name, "_start"}, 20);
    wait_busy(1'b0, {name, "_end"}, 400);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    loop            = 1'b1;
    miso_val        = 1'b0;
    bus.en_i        = 1'b0;
    bus.rx_full_i   = 1'b0;
`ifdef SPI_MODE_SEL_EN
    bus.cpol_i      = 1'b0;
    bus.cpha_i      = 1'b0;
`endif
    repeat (3) @(negedge clk);

    check("rst_cs_n",    32'(bus.cs_n_o),    32'h1);
    check("rst_sclk",    32'(bus.sclk_o),    32'h0);
    check("rst_mosi",    32'(bus.mosi_o),    32'h0);
    check("rst_busy",    32'(bus.busy_o),    32'h0);
    check("rst_ovf",     32'(bus.rx_ovf_o),  32'h0);
    check("rst_push",    32'(bus.rx_push_o), 32'h0);
    check("rst_pull",    32'(bus.tx_pull_o), 32'h0);
    check("rst_rx_data", 32'(bus.rx_data_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single word loopback
    snap();
    push_tx(8'hA5);
    push_exp(8'hA5);
    bus.en_i = 1'b1;
    run_word("t1");
    check("t1_pulls",  32'(pull_cnt - b_pull), 32'd1);
    check("t1_pushes", 32'(push_cnt - b_push), 32'd1);
    check("t1_rises",  32'(rise_cnt - b_rise), 32'd8);
    check("t1_mosi",   32'(mosi_bits[7:0]),    32'hA5);
    check("t1_cs_len", 32'(cs_last),           32'd37);
    check("t1_busy",   32'(bus.busy_o),        32'h0);
    bus.en_i = 1'b0;

    // Two-word burst, MISO tied high
    loop     = 1'b0;
    miso_val = 1'b1;
    snap();
    push_tx(8'h3C);
    push_tx(8'hC3);
    push_exp(8'hFF);
    push_exp(8'hFF);
    bus.en_i = 1'b1;
    run_word("t2");
    check("t2_pulls",     32'(pull_cnt - b_pull), 32'd2);
    check("t2_pushes",    32'(push_cnt - b_push), 32'd2);
    check("t2_push_pull", 32'(both_cnt - b_both), 32'd1);
    check("t2_rises",     32'(rise_cnt - b_rise), 32'd16);
    check("t2_cs_len",    32'(cs_last),           32'd70);
    bus.en_i = 1'b0;
    loop     = 1'b1;

    // No start while TX empty, then while RX full
    snap();
    bus.en_i = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_empty_pulls", 32'(pull_cnt - b_pull), 32'd0);
    check("t3_empty_cslow", 32'(cs_low - b_cslow),  32'd0);
    check("t3_empty_rises", 32'(rise_cnt - b_rise), 32'd0);
    bus.rx_full_i = 1'b1;
    push_tx(8'h77);
    repeat (40) @(negedge clk);
    check("t3_full_pulls", 32'(pull_cnt - b_pull), 32'd0);
    check("t3_full_cslow", 32'(cs_low - b_cslow),  32'd0);
    check("t3_full_sclk",  32'(bus.sclk_o),        32'h0);
    push_exp(8'h77);
    bus.rx_full_i = 1'b0;
    run_word("t3");
    check("t3_pushes", 32'(push_cnt - b_push), 32'd1);
    bus.en_i = 1'b0;

    // en_i dropped mid-word with a second word queued
    snap();
    push_tx(8'h96);
    push_tx(8'h69);
    push_exp(8'h96);
    bus.en_i = 1'b1;
    wait_rise(b_rise + 3, "t5_rise", 200);
    bus.en_i = 1'b0;
    wait_busy(1'b0, "t5_end", 400);
    @(negedge clk);
    check("t5_pulls",   32'(pull_cnt - b_pull), 32'd1);
    check("t5_pushes",  32'(push_cnt - b_push), 32'd1);
    check("t5_cs_n",    32'(bus.cs_n_o),        32'h1);
    check("t5_cs_len",  32'(cs_last),           32'd37);
    check("t5_left",    32'(tx_wr - tx_rd),     32'd1);

    // RX full raised mid-word: push still issued, overflow flag latches
    snap();
    push_exp(8'h69);
    bus.en_i = 1'b1;
    wait_rise(b_rise + 2, "ovf_rise", 200);
    bus.rx_full_i = 1'b1;
    wait_busy(1'b0, "ovf_end", 400);
    @(negedge clk);
    check("ovf_flag",   32'(bus.rx_ovf_o),      32'h1);
    check("ovf_pushes", 32'(push_cnt - b_push), 32'd1);
    bus.rx_full_i = 1'b0;
    bus.en_i      = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_sticky", 32'(bus.rx_ovf_o), 32'h1);

    // Reset at the 4th rising sclk edge aborts the word; the next word goes through
    snap();
    push_tx(8'h11);
    push_tx(8'h22);
    push_exp(8'h22);
    bus.en_i = 1'b1;
    wait_rise(b_rise + 4, "t4_rise", 200);
    rst = 1'b1;
    #1;
    check("t4_rst_cs_n", 32'(bus.cs_n_o), 32'h1);
    check("t4_rst_sclk", 32'(bus.sclk_o), 32'h0);
    check("t4_rst_busy", 32'(bus.busy_o), 32'h0);
    repeat (2) @(negedge clk);
    check("t4_rst_ovf",    32'(bus.rx_ovf_o),      32'h0);
    check("t4_rst_pushes", 32'(push_cnt - b_push), 32'd0);
    rst = 1'b0;
    run_word("t4");
    check("t4_pulls",  32'(pull_cnt - b_pull), 32'd2);
    check("t4_pushes", 32'(push_cnt - b_push), 32'd1);
    check("t4_cs_len", 32'(cs_last),           32'd37);
    bus.en_i = 1'b0;

`ifdef SPI_MODE_SEL_EN
    // Mode 3 loopback: sclk idles high, MOSI moves only on falling sclk
    bus.cpol_i = 1'b1;
    bus.cpha_i = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_idle_sclk", 32'(bus.sclk_o), 32'h1);
    snap();
    push_tx(8'h5A);
    push_exp(8'h5A);
    bus.en_i = 1'b1;
    run_word("t6");
    check("t6_rises",    32'(rise_cnt - b_rise),  32'd8);
    check("t6_mosi",     32'(mosi_bits[7:0]),     32'h5A);
    check("t6_mosi_edge", 32'(bad_mosi - b_bad),  32'd0);
    check("t6_end_sclk", 32'(bus.sclk_o),         32'h1);
    bus.en_i   = 1'b0;
    bus.cpol_i = 1'b0;
    bus.cpha_i = 1'b0;
    repeat (2) @(negedge clk);
`endif

    check("all_pushes_seen", 32'(exp_rd), 32'(exp_wr));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
